// File: rtl/seq_mult16_if.sv
// Handshake and operand/result bundle between the multicycle control unit
// (master) and the iterative multiplier (slave).
interface seq_mult16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;

    modport master (
        output start, op_a, op_b, signed_mode,
        input  busy, done, result_lo, result_hi
    );

    modport slave (
        input  start, op_a, op_b, signed_mode,
        output busy, done, result_lo, result_hi
    );
endinterface

// File: rtl/seq_mult16.sv
// Iterative shift-add WIDTH x WIDTH multiplier with start/done handshake.
// Signed operands are reduced to magnitudes on capture; the sign is applied
// once to the 2*WIDTH accumulator when the last iteration has completed.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for start; results hold their last value
//   S_RUN    | one multiplier bit per cycle, LSB first, WIDTH cycles
//   S_FINISH | apply sign, load results, pulse done, return to S_IDLE
module seq_mult16 #(
    parameter int WIDTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    seq_mult16_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CW-1:0]        r_count;
    logic                 r_neg;
    logic                 r_done;
    logic [WIDTH-1:0]     r_res_lo;
    logic [WIDTH-1:0]     r_res_hi;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_neg_in;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_result;

    // Magnitudes wrap naturally: the most negative value maps to itself,
    // which is its correct unsigned magnitude.
    assign w_a_mag  = (bus.signed_mode && bus.op_a[WIDTH-1]) ? (~bus.op_a + 1'b1) : bus.op_a;
    assign w_b_mag  = (bus.signed_mode && bus.op_b[WIDTH-1]) ? (~bus.op_b + 1'b1) : bus.op_b;
    assign w_neg_in = bus.signed_mode & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_last   = (r_count == CW'(WIDTH - 1));
    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign w_result = r_neg ? ({(2*WIDTH){1'b0}} - r_acc) : r_acc;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_RUN;
            S_RUN:    if (w_last)   w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Operand capture, shift-add iteration and result load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
            r_res_lo <= '0;
            r_res_hi <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= w_neg_in;
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                S_RUN: begin
                    // Shifting the multiplicand each cycle is the same as
                    // adding it shifted by the iteration count.
                    r_acc    <= r_acc + w_addend;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                end
                S_FINISH: begin
                    r_res_lo <= w_result[WIDTH-1:0];
                    r_res_hi <= w_result[2*WIDTH-1:WIDTH];
                    r_done   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.result_lo = r_res_lo;
    assign bus.result_hi = r_res_hi;
endmodule

// File: tb/tb_seq_mult16.sv
// Self-checking bench for seq_mult16: expected products and start cycles are
// queued when an accepted start is driven and consumed on each done pulse.
module tb_seq_mult16;
    logic clock = 1'b0;
    logic reset = 1'b1;

    seq_mult16_if #(.WIDTH(16)) mif ();

    seq_mult16 #(.WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (mif.slave)
    );

    always #5 clock = ~clock;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_bad = 0;
    int          busy_run = 0;
    logic [31:0] exp_q[$];
    int          cyc_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        if (s) begin
            sa = {{16{a[15]}}, a};
            sb = {{16{b[15]}}, b};
            return sa * sb;
        end
        return {16'h0, a} * {16'h0, b};
    endfunction

    // Monitor: sample 1 time unit after each rising edge.
    always @(posedge clock) begin
        logic [31:0] e;
        int          c0;
        #1;
        if (reset) begin
            busy_run = 0;
        end else begin
            if (mif.busy) busy_run++;
            if (mif.done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    c0 = cyc_q.pop_front();
                    check("product", {mif.result_hi, mif.result_lo}, e);
                    check("latency", 32'(cyc - c0), 32'd17);
                    check("busy_len", 32'(busy_run), 32'd17);
                    check("busy_at_done", {31'd0, mif.busy}, 32'd0);
                end
            end
            if (!mif.busy) busy_run = 0;
        end
    end

    // Drive one accepted start (DUT must be idle at the next edge), then
    // scramble the operand inputs, which must have no effect.
    task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input logic s);
        @(negedge clock);
        mif.start       = 1'b1;
        mif.op_a        = a;
        mif.op_b        = b;
        mif.signed_mode = s;
        exp_q.push_back(model(a, b, s));
        cyc_q.push_back(cyc + 1);
        @(negedge clock);
        mif.start       = 1'b0;
        mif.op_a        = 16'($urandom);
        mif.op_b        = 16'($urandom);
        mif.signed_mode = ~s;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    initial begin
        int c0;
        int n;
        mif.start       = 1'b0;
        mif.op_a        = '0;
        mif.op_b        = '0;
        mif.signed_mode = 1'b0;

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_busy", {31'd0, mif.busy}, 32'd0);
        check("rst_done", {31'd0, mif.done}, 32'd0);
        check("rst_lo", {16'd0, mif.result_lo}, 32'd0);
        check("rst_hi", {16'd0, mif.result_hi}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Directed products.
        do_mul(16'h0003, 16'h0005, 1'b0); wait_drain();
        check("lo_3x5", {16'd0, mif.result_lo}, 32'h0000_000F);
        do_mul(16'hFFFF, 16'hFFFF, 1'b0); wait_drain();
        do_mul(16'hFFFF, 16'hFFFF, 1'b1); wait_drain();
        do_mul(16'h8000, 16'h8000, 1'b1); wait_drain();
        do_mul(16'hFFFD, 16'h0007, 1'b1); wait_drain();
        do_mul(16'h0000, 16'h8000, 1'b1); wait_drain();
        do_mul(16'h8000, 16'h0000, 1'b0); wait_drain();
        do_mul(16'h8000, 16'h7FFF, 1'b1); wait_drain();

        // Results hold between operations.
        repeat (4) @(negedge clock);
        check("hold_idle", {mif.result_hi, mif.result_lo}, model(16'h8000, 16'h7FFF, 1'b1));

        // A start while busy is ignored.
        do_mul(16'h0003, 16'h0005, 1'b0);
        repeat (4) @(negedge clock);
        mif.start = 1'b1;
        mif.op_a  = 16'h0100;
        mif.op_b  = 16'h0100;
        @(negedge clock);
        mif.start = 1'b0;
        wait_drain();
        repeat (20) @(negedge clock);

        // Back-to-back: start held through the done cycle.
        do_mul(16'h0003, 16'h0005, 1'b0);
        mif.start       = 1'b1;
        mif.op_a        = 16'h0002;
        mif.op_b        = 16'h0002;
        mif.signed_mode = 1'b0;
        n = 0;
        while (!mif.done && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("b2b_done_seen", {31'd0, mif.done}, 32'd1);
        exp_q.push_back(32'h0000_0004);
        cyc_q.push_back(cyc + 1);
        @(negedge clock);
        mif.start = 1'b0;
        repeat (5) @(negedge clock);
        check("b2b_busy", {31'd0, mif.busy}, 32'd1);
        check("b2b_hold", {mif.result_hi, mif.result_lo}, 32'h0000_000F);
        wait_drain();

        // Random operands, random mode.
        for (int i = 0; i < 6; i++) begin
            do_mul(16'($urandom), 16'($urandom), 1'($urandom));
            wait_drain();
        end

        // Asynchronous reset in the middle of an operation.
        do_mul(16'h1234, 16'h5678, 1'b0);
        c0 = cyc_q[cyc_q.size() - 1];
        while (cyc < c0 + 8) @(negedge clock);
        #2;
        reset = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        #1;
        check("arst_busy", {31'd0, mif.busy}, 32'd0);
        check("arst_done", {31'd0, mif.done}, 32'd0);
        check("arst_res", {mif.result_hi, mif.result_lo}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (25) @(negedge clock);
        check("arst_idle", {31'd0, mif.busy}, 32'd0);
        do_mul(16'h0002, 16'h0003, 1'b0); wait_drain();
        check("post_rst", {mif.result_hi, mif.result_lo}, 32'h0000_0006);

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_mult16.md
Name: seq_mult16

Overview:
Iterative shift-add 16x16 multiplier with a start/done handshake. Sits downstream of the ALU operand-select 4:1 mux and consumes its registered 16-bit outputs as operands. The multicycle control unit starts it for MUL instructions and stalls until done; result_lo/result_hi then feed the register-file write-data mux.

Parameters:
WIDTH, 16, operand width; product is 2*WIDTH bits; iteration count equals WIDTH.

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state and outputs
start  input  1  request a multiply; sampled only in IDLE
op_a  input  WIDTH  multiplicand (from operand mux)
op_b  input  WIDTH  multiplier (from operand mux)
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse, result valid
result_lo  output  WIDTH  product bits [WIDTH-1:0]
result_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH]

Behaviour:
- Reset (any time, including mid-operation): state=IDLE, busy=0, done=0, result_lo=0, result_hi=0, internal accumulator/counter/operand copies=0. In-flight operation is discarded.
- States: IDLE, RUN, FINISH.
- IDLE: at a posedge with start=1 (edge E0), capture op_a, op_b, signed_mode. In signed mode, store magnitudes (|0x8000| = 0x8000 as unsigned, no overflow) and neg_flag = a[MSB] XOR b[MSB]; in unsigned mode, neg_flag=0. Clear 2*WIDTH accumulator, count=0, go to RUN, busy=1 from E0.
- RUN: one multiplier bit per cycle, LSB first: if current multiplier bit is 1, accumulator += multiplicand shifted by count (unsigned, 2*WIDTH bits, no overflow is possible). count increments; after WIDTH iterations (edges E1..E16 for WIDTH=16) go to FINISH.
- FINISH (edge E17): result = neg_flag ? two's-complement negation of accumulator (2*WIDTH bits) : accumulator; load result_hi/result_lo; done=1; busy=0; state=IDLE.
- done high for exactly the one cycle following E17, then 0 at E18 unless the next operation finishes.
- Latency: start edge to result-valid edge = WIDTH+1 clocks (17). busy is high for exactly WIDTH+1 cycles per operation.
- start while busy=1: ignored, no effect on the running operation or the captured operands.
- start=1 during the done cycle: state is IDLE, so it is accepted; the new operation begins and done still drops at the next edge.
- op_a/op_b/signed_mode changes after E0: no effect.
- result_lo/result_hi hold their last value between completions and while a new operation runs; they change only at FINISH or reset.
- Zero operand: runs the full WIDTH+1 cycles (no early termination); result 0. Signed zero with a negative other operand: result 0 (negating 0 yields 0).
- Arithmetic: product computed at 2*WIDTH bits; signed result is the exact two's-complement product, and unsigned result is the exact unsigned product. No truncation or saturation.

Test Plan:
- Unsigned 0x0003 * 0x0005, start 1 cycle -> busy for 17 cycles; done pulse 17 clocks after the start edge; result_hi=0x0000, result_lo=0x000F.
- Unsigned 0xFFFF * 0xFFFF -> {hi,lo}=0xFFFE_0001; signed_mode=1 with same operands -> 0x0000_0001.
- Signed 0x8000 * 0x8000 -> 0x4000_0000; signed 0xFFFD (-3) * 0x0007 -> 0xFFFF_FFEB; signed 0x0000 * 0x8000 -> 0x0000_0000.
- Start 3+5, then on cycle 6 drive start=1 with op_a=0x0100, op_b=0x0100 -> ignored; result 0x0000_000F at the original done time; busy never re-extends.
- Back-to-back: start=1 held through the done cycle with 2*2 -> the second operation is accepted in the done cycle; its done comes 17 cycles later with result 0x0000_0004; the first result stays visible in between.
- Assert reset at cycle 8 of a 0x1234*0x5678 operation -> busy, done, and results go 0 immediately (asynchronously); no done pulse follows; a new 2*3 afterwards gives 0x0000_0006.
